// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the stream round-robin arbiter.
// Feature macro: STREAM_RR_ARBITER_PKT_LOCK_EN selects packet-locked grants
// (consumed by stream_rr_arbiter); this package is mode independent.
package stream_arb_pkg;

  // Largest supported requester count and the index width that covers it.
  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = $clog2(MAX_REQ);

  // Arbiter grant state.
  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  // Rotate-priority pick: first set bit of req scanning ptr+1, ptr+2, ...
  // with wrap, ptr itself last. Callers with fewer than MAX_REQ requesters
  // zero-extend req; the zero padding above their top index makes the
  // MAX_REQ-wide wrap equivalent to a wrap at their own count.
  function automatic logic [MAX_IDX_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0]   req,
    input logic [MAX_IDX_W-1:0] ptr
  );
    logic [MAX_IDX_W-1:0] idx;
    logic [MAX_IDX_W-1:0] cand;
    logic                 found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      cand = ptr + MAX_IDX_W'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_rr_pick.sv
// Combinational rotate-priority picker used by stream_rr_arbiter.
// Mode independent (STREAM_RR_ARBITER_PKT_LOCK_EN does not affect it).
module stream_rr_pick
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [MAX_REQ-1:0]   req_ext;
  logic [MAX_IDX_W-1:0] ptr_ext;

  // Widen request vector and pointer to the package helper's fixed width.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    ptr_ext                = MAX_IDX_W'(ptr);
  end

  // Winner index (always below NUM_REQ, so the narrowing is lossless).
  always_comb begin
    idx = IDX_W'(rr_pick(req_ext, ptr_ext));
    any = |req;
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready beat stream between NUM_REQ
// requesters, with a single registered output stage tagged by source index.
// Feature macro: STREAM_RR_ARBITER_PKT_LOCK_EN
//   defined   : grant is held until a beat with req_last=1 transfers.
//   undefined : grant is released after MAX_BURST beats or when the granted
//               requester drops valid without transferring.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_last,
  output logic [$clog2(NUM_REQ)-1:0]  out_src
);

  localparam int         SRC_W   = $clog2(NUM_REQ);
  localparam logic [7:0] CNT_MAX = 8'hFF;
`ifndef STREAM_RR_ARBITER_PKT_LOCK_EN
  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);
`endif

  arb_state_e        state;
  logic [SRC_W-1:0]  grant;
  logic [SRC_W-1:0]  rr_ptr;
  logic [7:0]        beat_cnt;
  logic [7:0]        beat_cnt_inc;

  logic [SRC_W-1:0]  pick_idx;
  logic              pick_any;

  logic [DATA_W-1:0] lane_data [NUM_REQ];
  logic              g_valid;
  logic              g_last;
  logic [DATA_W-1:0] g_data;

  logic              out_free;
  logic              xfer;
  logic              release_grant;

  // Next-grant candidate: first valid requester after the last released one.
  stream_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Split the flattened data bus into one lane per requester.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      lane_data[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Select the granted requester's beat.
  always_comb begin
    g_valid = req_valid[grant];
    g_last  = req_last[grant];
    g_data  = lane_data[grant];
  end

  // Handshake: the output register can take a beat when empty or draining.
  always_comb begin
    out_free  = !out_valid || out_ready;
    xfer      = (state == ARB_BUSY) && g_valid && out_free;
    req_ready = '0;
    if ((state == ARB_BUSY) && out_free) begin
      req_ready[grant] = 1'b1;
    end
  end

  // Saturating beat count and mode-dependent grant release condition.
  always_comb begin
    beat_cnt_inc = (beat_cnt == CNT_MAX) ? CNT_MAX : beat_cnt + 8'd1;
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
    release_grant = xfer && g_last;
`else
    release_grant = (xfer && (beat_cnt_inc == BURST_LIM)) || !g_valid;
`endif
  end

  // Grant FSM, beat counter and registered output stage.
  // A release and a transfer can coincide: the output stage is updated
  // independently of the state case, so the final beat is still forwarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      rr_ptr    <= SRC_W'(NUM_REQ - 1);
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_last  <= g_last;
        out_src   <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant <= pick_idx;
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (xfer) begin
            beat_cnt <= beat_cnt_inc;
          end
          if (release_grant) begin
            rr_ptr   <= grant;
            beat_cnt <= '0;
            state    <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed scenarios plus random
// traffic, every cycle compared with a behavioural model of the arbiter.
// Honours STREAM_RR_ARBITER_PKT_LOCK_EN the same way as the design.
module tb_stream_rr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 16;
  localparam int SRC_W     = 2;
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
  localparam bit PKT_MODE = 1'b1;
`else
  localparam bit PKT_MODE = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic [SRC_W-1:0]          out_src;

  always #5 clk = ~clk;

  stream_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_last  (req_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Source queues: each entry is data | (last << 8).
  int unsigned q[NUM_REQ][$];
  bit          gate[NUM_REQ];
  bit          cur_v[NUM_REQ];
  int          pops[NUM_REQ];

  // Behavioural model of the arbiter.
  bit m_busy;
  int m_g, m_ptr, m_cnt;
  bit m_ov;
  int m_od, m_ol, m_os;

  typedef struct {
    int src;
    int data;
    int last;
    int cyc;
  } obs_t;
  obs_t obs[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_busy = 1'b0;
    m_g    = 0;
    m_ptr  = NUM_REQ - 1;
    m_cnt  = 0;
    m_ov   = 1'b0;
    m_od   = 0;
    m_ol   = 0;
    m_os   = 0;
  endfunction

  function automatic void clear_sources();
    for (int i = 0; i < NUM_REQ; i++) begin
      q[i].delete();
      gate[i] = 1'b0;
      pops[i] = 0;
    end
  endfunction

  // Advance the model by one clock edge, popping the source that transferred.
  function automatic void model_step();
    bit was_busy;
    bit x;
    bit rel;
    int hd;
    was_busy = m_busy;
    x = m_busy && cur_v[m_g] && (!m_ov || out_ready);
    if (x) begin
      hd   = int'(q[m_g].pop_front());
      m_ov = 1'b1;
      m_od = hd & 'hFF;
      m_ol = (hd >> 8) & 1;
      m_os = m_g;
      pops[m_g]++;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    if (!was_busy) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (cur_v[(m_ptr + k) % NUM_REQ]) begin
          m_g    = (m_ptr + k) % NUM_REQ;
          m_busy = 1'b1;
          break;
        end
      end
    end else begin
      if (x && m_cnt < 255) m_cnt++;
      if (PKT_MODE) rel = x && (m_ol == 1);
      else          rel = (x && m_cnt == MAX_BURST) || !cur_v[m_g];
      if (rel) begin
        m_ptr  = m_g;
        m_cnt  = 0;
        m_busy = 1'b0;
      end
    end
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      cur_v[i]     = gate[i] && (q[i].size() > 0);
      req_valid[i] = cur_v[i];
      if (q[i].size() > 0) begin
        req_data[i*DATA_W +: DATA_W] = DATA_W'(q[i][0] & 'hFF);
        req_last[i]                  = ((q[i][0] >> 8) & 1) != 0;
      end else begin
        req_data[i*DATA_W +: DATA_W] = '0;
        req_last[i]                  = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    int er;
    er = (m_busy && (!m_ov || out_ready)) ? (1 << m_g) : 0;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data",  32'(out_data),  32'(m_od));
    chk("out_last",  32'(out_last),  32'(m_ol));
    chk("out_src",   32'(out_src),   32'(m_os));
    if (out_valid && out_ready)
      obs.push_back('{int'(out_src), int'(out_data), int'(out_last), cyc});
  endtask

  // One clock: drive, check at the falling edge, step the model at the rising edge.
  task automatic cycle();
    apply_inputs();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
    cyc++;
  endtask

  task automatic drain(input int max_cyc);
    int t;
    int left;
    for (int i = 0; i < NUM_REQ; i++) gate[i] = 1'b1;
    out_ready = 1'b1;
    t = 0;
    left = 1;
    while (left != 0 && t < max_cyc) begin
      cycle();
      t++;
      left = int'(m_ov);
      for (int i = 0; i < NUM_REQ; i++) left += q[i].size();
    end
    chk("drain_left", 32'(left), 32'd0);
  endtask

  initial begin
    int t, n0, hold;
    bit dropped;
    reset_n   = 1'b0;
    out_ready = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    clear_sources();
    model_reset();
    @(posedge clk);
    #1;

    // 1: all four valid through reset, one beat each; grants rotate 0..3.
    for (int i = 0; i < NUM_REQ; i++) begin
      gate[i] = 1'b1;
      q[i].push_back(32'(('h40 + i) | 'h100));
    end
    out_ready = 1'b1;
    repeat (3) cycle();
    reset_n = 1'b1;
    obs.delete();
    for (t = 0; t < 40 && obs.size() < 4; t++) cycle();
    chk("t1_count", 32'(obs.size()), 32'd4);
    for (int k = 0; k < obs.size() && k < 4; k++) chk("t1_src", 32'(obs[k].src), 32'(k));
    drain(20);

    // 2: only requester 2, 32 beats 0x11..0x30.
    obs.delete();
    for (int b = 0; b < 32; b++) q[2].push_back(32'((16'h11 + b) | ((b == 31) ? 'h100 : 0)));
    for (t = 0; t < 100 && obs.size() < 32; t++) cycle();
    chk("t2_count", 32'(obs.size()), 32'd32);
    for (int k = 0; k < obs.size() && k < 32; k++) begin
      chk("t2_src",  32'(obs[k].src),  32'd2);
      chk("t2_data", 32'(obs[k].data), 32'('h11 + k));
      if (k > 0)
        chk("t2_gap", 32'(obs[k].cyc - obs[k-1].cyc), (!PKT_MODE && k == 16) ? 32'd2 : 32'd1);
    end
    drain(20);

    // 3: stall with 0xA5 held in the output register.
    obs.delete();
    q[1].push_back(32'h0A5);
    q[1].push_back(32'h15A);
    t = 0;
    while (!(out_valid && out_data == 8'hA5) && t < 20) begin
      cycle();
      t++;
    end
    chk("t3_seen", 32'(out_valid && out_data == 8'hA5), 32'd1);
    out_ready = 1'b0;
    repeat (5) begin
      cycle();
      chk("t3_hold_data",  32'(out_data),  32'hA5);
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_rdy",   32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    for (t = 0; t < 20 && obs.size() < 2; t++) cycle();
    chk("t3_count", 32'(obs.size()), 32'd2);
    if (obs.size() >= 2) begin
      chk("t3_first",  32'(obs[0].data), 32'hA5);
      chk("t3_second", 32'(obs[1].data), 32'h5A);
      chk("t3_src",    32'(obs[0].src),  32'd1);
    end
    drain(20);

`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
    // 4: req0 packet with a 3-cycle valid gap after beat 2; req1 always valid.
    reset_n = 1'b0;
    model_reset();
    clear_sources();
    for (int b = 1; b <= 4; b++) q[0].push_back(32'(b | ((b == 4) ? 'h100 : 0)));
    for (int b = 0; b < 6; b++) q[1].push_back(32'(('h81 + b) | 'h100));
    gate[0] = 1'b1;
    gate[1] = 1'b1;
    cycle();
    reset_n = 1'b1;
    obs.delete();
    dropped = 1'b0;
    hold = 0;
    for (t = 0; t < 80 && pops[0] < 4; t++) begin
      cycle();
      if (!dropped && pops[0] == 2) begin
        gate[0] = 1'b0;
        hold = 3;
        dropped = 1'b1;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) gate[0] = 1'b1;
      end
    end
    repeat (3) cycle();
    n0 = 0;
    foreach (obs[k]) begin
      if (obs[k].src == 1) break;
      if (obs[k].src == 0) n0++;
    end
    chk("t4_pkt_first", 32'(n0), 32'd4);
    drain(40);
`endif

    // Random traffic, random gaps and backpressure.
    for (int r = 0; r < 1500; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 9) == 0 && q[i].size() < 24) begin
          int len;
          len = int'($urandom_range(1, 6));
          for (int b = 0; b < len; b++)
            q[i].push_back(($urandom & 'hFF) | ((b == len - 1) ? 'h100 : 0));
        end
        gate[i] = ($urandom_range(0, 9) < 8);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain(400);

    // 5: asynchronous reset mid-burst, then lowest valid index wins.
    for (int b = 0; b < 10; b++) q[0].push_back(32'(('hC0 + b) | ((b == 9) ? 'h100 : 0)));
    t = 0;
    while (!out_valid && t < 20) begin
      cycle();
      t++;
    end
    chk("t5_busy", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    model_reset();
    clear_sources();
    q[1].push_back(32'h131);
    q[3].push_back(32'h133);
    gate[1] = 1'b1;
    gate[3] = 1'b1;
    repeat (2) cycle();
    reset_n = 1'b1;
    obs.delete();
    for (t = 0; t < 20 && obs.size() < 1; t++) cycle();
    chk("t5_count", 32'(obs.size()), 32'd1);
    if (obs.size() >= 1) chk("t5_first_src", 32'(obs[0].src), 32'd1);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
